// File: rtl/shift_pkg.sv
// Shared encodings for the universal shift register: idle-time operation
// select values and the two-state burst controller encoding.
package shift_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_SHR  = 2'b11
    } mode_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage : shift_pkg

// File: rtl/shift_reg_univ.sv
// Universal shift register with hold/load/shift-left/shift-right while idle,
// plus a start-triggered burst that serialises d LSB first on sout.
module shift_reg_univ
    import shift_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_reg;
    logic [WIDTH-1:0] q_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             done_reg;

    logic [WIDTH-1:0] shl_next;
    logic [WIDTH-1:0] shr_next;

    assign shl_next = {q_reg[WIDTH-2:0], sin};
    assign shr_next = {sin, q_reg[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
            q_reg     <= RESET_VAL;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            unique case (state_reg)
                ST_IDLE: begin
                    // start outranks en/mode so a burst can never be lost
                    if (start) begin
                        q_reg     <= d;
                        cnt_reg   <= '0;
                        state_reg <= ST_SHIFT;
                    end else if (en) begin
                        case (mode)
                            MODE_LOAD: q_reg <= d;
                            MODE_SHL:  q_reg <= shl_next;
                            MODE_SHR:  q_reg <= shr_next;
                            default:   q_reg <= q_reg;
                        endcase
                    end
                end
                ST_SHIFT: begin
                    q_reg <= shr_next;
                    if (cnt_reg == CNT_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_IDLE;
                        done_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign q    = q_reg;
    assign busy = (state_reg == ST_SHIFT);
    assign done = done_reg;

    // Left shifts push out the MSB; everything else drains from the LSB.
    always_comb begin
        sout = q_reg[0];
        if (state_reg == ST_IDLE && mode == MODE_SHL)
            sout = q_reg[WIDTH-1];
    end

endmodule : shift_reg_univ
